// File: rtl/demux_desc_lanes_tarea34_if.sv
// Bundle of signals between the upstream select-mux/flop stage, the lane
// consumers and the two-lane demux FIFO.
//   master : drives valid_in/selector_in/data_in and pop0/pop1, observes
//            read data, valid and status flags.
//   slave  : the demux FIFO itself.
interface demux_desc_lanes_tarea34_if #(
  parameter int DATA_W = 2
);
  logic              valid_in;
  logic              selector_in;
  logic [DATA_W-1:0] data_in;
  logic              pop0;
  logic              pop1;
  logic [DATA_W-1:0] data_out0;
  logic [DATA_W-1:0] data_out1;
  logic              valid_out0;
  logic              valid_out1;
  logic              full0;
  logic              full1;
  logic              empty0;
  logic              empty1;
  logic              overflow;
  logic              underflow;

  modport master (
    output valid_in, selector_in, data_in, pop0, pop1,
    input  data_out0, data_out1, valid_out0, valid_out1,
    input  full0, full1, empty0, empty1, overflow, underflow
  );

  modport slave (
    input  valid_in, selector_in, data_in, pop0, pop1,
    output data_out0, data_out1, valid_out0, valid_out1,
    output full0, full1, empty0, empty1, overflow, underflow
  );
endinterface

// File: rtl/demux_desc_lanes_tarea34.sv
// Two-lane demux FIFO: steers each valid upstream word into the lane FIFO
// named by selector_in, and lets each lane be drained by its own pop.
// Ports:
//   clk     : rising-edge clock
//   reset_L : asynchronous active-low reset
//   bus     : slave side of demux_desc_lanes_tarea34_if (push stream,
//             per-lane pop/read data/valid, full/empty, sticky errors)
module demux_desc_lanes_tarea34 #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic                          clk,
  input  logic                          reset_L,
  demux_desc_lanes_tarea34_if.slave     bus
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_W-1:0] mem_q [2][DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q [2];
  logic [PTR_W-1:0]  wr_ptr_d [2];
  logic [PTR_W-1:0]  rd_ptr_q [2];
  logic [PTR_W-1:0]  rd_ptr_d [2];
  logic [PTR_W:0]    cnt_q    [2];
  logic [PTR_W:0]    cnt_d    [2];
  logic [DATA_W-1:0] dout_q   [2];
  logic [DATA_W-1:0] dout_d   [2];
  logic [1:0]        vout_q, vout_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic [1:0]        push_req, pop_req, push_acc, pop_acc;

  always_comb begin
    push_req[0] = bus.valid_in & ~bus.selector_in;
    push_req[1] = bus.valid_in &  bus.selector_in;
    pop_req     = {bus.pop1, bus.pop0};
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    for (int l = 0; l < 2; l++) begin
      pop_acc[l]  = pop_req[l] && (cnt_q[l] != '0);
      // A pop in the same cycle frees the slot, so a full lane still accepts.
      push_acc[l] = push_req[l] && ((cnt_q[l] != CNT_FULL) || pop_acc[l]);

      wr_ptr_d[l] = push_acc[l] ? wr_ptr_q[l] + PTR_ONE : wr_ptr_q[l];
      rd_ptr_d[l] = pop_acc[l]  ? rd_ptr_q[l] + PTR_ONE : rd_ptr_q[l];

      cnt_d[l] = cnt_q[l];
      if (push_acc[l] && !pop_acc[l]) begin
        cnt_d[l] = cnt_q[l] + CNT_ONE;
      end else if (pop_acc[l] && !push_acc[l]) begin
        cnt_d[l] = cnt_q[l] - CNT_ONE;
      end

      vout_d[l] = pop_acc[l];
      dout_d[l] = pop_acc[l] ? mem_q[l][rd_ptr_q[l]] : dout_q[l];

      if (push_req[l] && !push_acc[l]) begin
        ovf_d = 1'b1;
      end
      if (pop_req[l] && !pop_acc[l]) begin
        udf_d = 1'b1;
      end
    end
  end

  // Storage is intentionally left out of reset; pointers/counts define validity.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (push_acc[l]) begin
        mem_q[l][wr_ptr_q[l]] <= bus.data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int l = 0; l < 2; l++) begin
        wr_ptr_q[l] <= '0;
        rd_ptr_q[l] <= '0;
        cnt_q[l]    <= '0;
        dout_q[l]   <= '0;
      end
      vout_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        wr_ptr_q[l] <= wr_ptr_d[l];
        rd_ptr_q[l] <= rd_ptr_d[l];
        cnt_q[l]    <= cnt_d[l];
        dout_q[l]   <= dout_d[l];
      end
      vout_q <= vout_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  assign bus.data_out0  = dout_q[0];
  assign bus.data_out1  = dout_q[1];
  assign bus.valid_out0 = vout_q[0];
  assign bus.valid_out1 = vout_q[1];
  assign bus.full0      = (cnt_q[0] == CNT_FULL);
  assign bus.full1      = (cnt_q[1] == CNT_FULL);
  assign bus.empty0     = (cnt_q[0] == '0);
  assign bus.empty1     = (cnt_q[1] == '0);
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = udf_q;

endmodule
